bram_arbiter: RTL
=================

BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 Parameter: FIXED_PRIO, default 0, 0 = round-robin between requesters, 1 = requester 0 always wins.
REQ-002 The block SHALL have one clock; reset is synchronous and active-low.
REQ-003 Port: clk  in  1  rising-edge clock for all state.
REQ-004 Port: rst  in  1  synchronous active-low reset.
REQ-005 Ports: req0_valid / req1_valid  in  1 each  request pending.
REQ-006 Ports: req0_ready / req1_ready  out  1 each  request accepted this cycle (valid & ready = handshake).
REQ-007 Ports: req0_we / req1_we  in  1 each  1 = write, 0 = read.
REQ-008 Ports: req0_addr / req1_addr  in  8 each  memory address.
REQ-009 Ports: req0_wdata / req1_wdata  in  8 each  write data.
REQ-010 Ports: rsp0_valid / rsp1_valid  out  1 each  one-cycle completion pulse.
REQ-011 Ports: rsp0_rdata / rsp1_rdata  out  8 each  memory word at the access address, sampled before any write.
REQ-012 Port: mem_addr  out  8  address to the 256x8 block RAM.
REQ-013 Port: mem_din  out  8  write data to the RAM.
REQ-014 Port: mem_wen  out  1  RAM write enable.
REQ-015 Port: mem_dout  in  8  RAM registered read data (valid one cycle after the address is presented).
REQ-016 Port: busy  out  1  high whenever state != IDLE.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE and WAIT; transitions: IDLE->ISSUE on handshake, ISSUE->WAIT unconditionally, WAIT->IDLE unconditionally.
REQ-018 In IDLE, ready SHALL be driven combinationally to at most one requester: the granted requester with valid high; no ready is asserted outside IDLE.
REQ-019 Round-robin (FIXED_PRIO=0): if both valid, grant the requester not granted last; if one valid, grant it; last_grant updates only on handshake.
REQ-020 FIXED_PRIO=1: requester 0 wins whenever req0_valid=1.
REQ-021 On handshake, we/addr/wdata and the grant index SHALL be latched; requester inputs are ignored until the next handshake.
REQ-022 In ISSUE and WAIT, mem_addr SHALL equal the latched address; mem_din SHALL equal the latched wdata.
REQ-023 mem_wen SHALL be 1 only in ISSUE with latched we=1 and rst=1; otherwise 0.
REQ-024 At the WAIT->IDLE edge, the block SHALL register mem_dout into rspN_rdata of the latched requester and pulse rspN_valid for exactly one cycle; the other rsp_valid stays 0.
REQ-025 Latency: handshake in cycle T -> ISSUE in T+1, WAIT in T+2, rsp_valid in T+3; the next ready may be asserted in T+3.
REQ-026 Writes SHALL also produce rsp_valid; rsp_rdata is the pre-write content (RAM read-before-write).
REQ-027 rspN_rdata SHALL hold its value until the next response to that requester.
REQ-028 Addresses 0x00..0xFF SHALL be valid with no wrap or special casing.
REQ-029 Round-robin SHALL guarantee at most one intervening grant to the other requester while a request is pending.
REQ-030 Throughput SHALL be one access per 3 cycles maximum.

Reset
REQ-031 While rst=0 at a clock edge: state<=IDLE, last_grant<=1 (so requester 0 wins first), latched regs<=0, rsp*_valid<=0, rsp*_rdata<=0.
REQ-032 While rst=0, all outputs SHALL be 0: ready, mem_wen, mem_addr, mem_din and busy.
REQ-033 Reset mid-operation SHALL abandon the access: no response, and no RAM write even if asserted during ISSUE; RAM contents are not cleared by this block.

Verification
REQ-034 Reset, req0 write addr 0x10 data 0xA5, then req1 read 0x10 -> rsp1_valid at handshake+3 with rsp1_rdata=0xA5, and rsp0_valid never coincides with it.
REQ-035 Both valid continuously, FIXED_PRIO=0 -> grant order 0,1,0,1, one handshake every 3 cycles; FIXED_PRIO=1 -> req1 never readied while req0_valid=1.
REQ-036 0x20 holds 0xA5, write 0x5A to 0x20 -> response rdata=0xA5; a following read of 0x20 -> 0x5A.
REQ-037 rst=0 during ISSUE of a write of 0x77 to 0x30 -> mem_wen=0, no rsp_valid, busy=0 next cycle, and a later read of 0x30 returns the old value.
REQ-038 Write 0xFF to 0xFF and 0x01 to 0x00, then read both -> 0xFF and 0x01.
REQ-039 Change req1_addr/wdata while req1_valid=1 and ready=0 -> the values sampled at the handshake are used, and pre-handshake values are ignored.

Source files
------------

// File: rtl/bram_arbiter_if.sv
// bram_arbiter_if
// Bundles the two requester channels of the BRAM arbiter into one interface.
//
// Signals (per requester N = 0, 1):
//   reqN_valid  request pending (requester -> arbiter)
//   reqN_ready  request accepted this cycle (arbiter -> requester)
//   reqN_we     1 = write, 0 = read
//   reqN_addr   8-bit memory address
//   reqN_wdata  8-bit write data
//   rspN_valid  one-cycle completion pulse (arbiter -> requester)
//   rspN_rdata  memory word at the access address, read before any write
//
// Modports:
//   slave  : arbiter side
//   master : requester side
interface bram_arbiter_if;
    logic       req0_valid;
    logic       req0_ready;
    logic       req0_we;
    logic [7:0] req0_addr;
    logic [7:0] req0_wdata;
    logic       rsp0_valid;
    logic [7:0] rsp0_rdata;

    logic       req1_valid;
    logic       req1_ready;
    logic       req1_we;
    logic [7:0] req1_addr;
    logic [7:0] req1_wdata;
    logic       rsp1_valid;
    logic [7:0] rsp1_rdata;

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        output req0_ready, rsp0_valid, rsp0_rdata,
        output req1_ready, rsp1_valid, rsp1_rdata
    );

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        input  req0_ready, rsp0_valid, rsp0_rdata,
        input  req1_ready, rsp1_valid, rsp1_rdata
    );
endinterface

// File: rtl/bram_arbiter.sv
// bram_arbiter
// Arbitrates two requesters onto a single-port 256x8 block RAM with a
// registered read port. Each access takes three cycles (IDLE -> ISSUE -> WAIT)
// and always returns the pre-write memory word as its response.
//
// Parameters:
//   FIXED_PRIO  0 = round-robin between requesters, 1 = requester 0 always wins
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-low reset
//   bus       requester channels (bram_arbiter_if.slave)
//   mem_addr  RAM address
//   mem_din   RAM write data
//   mem_wen   RAM write enable
//   mem_dout  RAM registered read data
//   busy      high whenever an access is in flight
module bram_arbiter #(
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst,
    bram_arbiter_if.slave     bus,
    output logic [7:0]        mem_addr,
    output logic [7:0]        mem_din,
    output logic              mem_wen,
    input  logic [7:0]        mem_dout,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic       last_grant;
    logic       grant;
    logic       handshake;
    logic       ready0;
    logic       ready1;
    logic       active;

    logic       lat_we;
    logic       lat_idx;
    logic [7:0] lat_addr;
    logic [7:0] lat_wdata;

    logic       rsp0_valid;
    logic       rsp1_valid;
    logic [7:0] rsp0_rdata;
    logic [7:0] rsp1_rdata;

    // Grant selection. When only one requester is valid the grant simply
    // points at it; with neither valid the value is irrelevant because no
    // ready is raised.
    always_comb begin
        grant = 1'b0;
        if (FIXED_PRIO != 0) begin
            grant = !bus.req0_valid;
        end else if (bus.req0_valid && bus.req1_valid) begin
            grant = !last_grant;
        end else begin
            grant = bus.req1_valid;
        end
    end

    // Ready is qualified by rst so nothing is accepted while reset is held.
    always_comb begin
        ready0    = (state == IDLE) && rst && bus.req0_valid && !grant;
        ready1    = (state == IDLE) && rst && bus.req1_valid &&  grant;
        handshake = ready0 || ready1;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (handshake) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The WAIT cycle sees the RAM's registered output for the address issued
    // in ISSUE, which is the pre-write word, so it is captured here.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            lat_we     <= 1'b0;
            lat_idx    <= 1'b0;
            lat_addr   <= 8'h00;
            lat_wdata  <= 8'h00;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_rdata <= 8'h00;
            rsp1_rdata <= 8'h00;
        end else begin
            state      <= state_next;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            if (handshake) begin
                last_grant <= grant;
                lat_idx    <= grant;
                lat_we     <= grant ? bus.req1_we    : bus.req0_we;
                lat_addr   <= grant ? bus.req1_addr  : bus.req0_addr;
                lat_wdata  <= grant ? bus.req1_wdata : bus.req0_wdata;
            end
            if (state == WAIT) begin
                if (lat_idx) begin
                    rsp1_valid <= 1'b1;
                    rsp1_rdata <= mem_dout;
                end else begin
                    rsp0_valid <= 1'b1;
                    rsp0_rdata <= mem_dout;
                end
            end
        end
    end

    // Memory-side outputs are gated by rst so a reset during ISSUE
    // suppresses the write on that very edge.
    always_comb begin
        active   = rst && (state != IDLE);
        busy     = active;
        mem_addr = active ? lat_addr  : 8'h00;
        mem_din  = active ? lat_wdata : 8'h00;
        mem_wen  = rst && (state == ISSUE) && lat_we;
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.rsp0_valid = rsp0_valid;
    assign bus.rsp1_valid = rsp1_valid;
    assign bus.rsp0_rdata = rsp0_rdata;
    assign bus.rsp1_rdata = rsp1_rdata;

endmodule
